// File: rtl/alu_div_ctrl.sv
// Request front-end for the ALU divider: queues signed 8-bit divide requests,
// issues them one at a time, and returns tagged quotients over valid/ready.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the FIFO head when one is present
// ISSUE | div_start high for this single cycle, watchdog cleared
// WAIT  | divider running; ends on div_done or watchdog expiry
// RESP  | response held on rsp_* until rsp_ready
module alu_div_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [7:0]       div_a,
  output logic [7:0]       div_b,
  input  logic [15:0]      div_quotient,
  input  logic             div_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_quotient,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dbz,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int ENT_W = 16 + TAG_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WD_W-1:0]    wdog_q;
  logic               div_start_q;
  logic [7:0]         div_a_q, div_b_q;
  logic               rsp_valid_q;
  logic [15:0]        rsp_quotient_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               rsp_dbz_q, rsp_timeout_q;

  logic               full, empty, push, pop;
  logic [ENT_W-1:0]   head;
  logic [7:0]         head_a, head_b;
  logic [TAG_W-1:0]   head_tag;

  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = req_valid && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign head     = mem_q[rd_ptr_q];
  assign head_a   = head[ENT_W-1 -: 8];
  assign head_b   = head[ENT_W-9 -: 8];
  assign head_tag = head[TAG_W-1:0];

  // Entry storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_a, req_b, req_tag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wdog_q         <= '0;
      div_start_q    <= 1'b0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_quotient_q <= '0;
      rsp_tag_q      <= '0;
      rsp_dbz_q      <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            div_a_q       <= head_a;
            div_b_q       <= head_b;
            rsp_tag_q     <= head_tag;
            rsp_timeout_q <= 1'b0;
            // A zero divisor is answered directly; the divider is never started.
            if (head_b == 8'd0) begin
              rsp_quotient_q <= '0;
              rsp_dbz_q      <= 1'b1;
              rsp_valid_q    <= 1'b1;
              state_q        <= RESP;
            end else begin
              rsp_dbz_q   <= 1'b0;
              div_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          div_start_q <= 1'b0;
          wdog_q      <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // div_done takes priority over a watchdog expiry in the same cycle.
          if (div_done) begin
            rsp_quotient_q <= div_quotient;
            rsp_dbz_q      <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            rsp_valid_q    <= 1'b1;
            state_q        <= RESP;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            rsp_quotient_q <= '0;
            rsp_dbz_q      <= 1'b0;
            rsp_timeout_q  <= 1'b1;
            rsp_valid_q    <= 1'b1;
            state_q        <= RESP;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = !full;
  assign div_start    = div_start_q;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_dbz      = rsp_dbz_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign busy         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Bench for alu_div_ctrl: behavioural divider model, in-order response
// scoreboard, table vectors, directed corner sequences and random traffic.
module tb_alu_div_ctrl;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 4;
  localparam int TIMEOUT    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [7:0]       req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             div_start;
  logic [7:0]       div_a, div_b;
  logic [15:0]      div_quotient;
  logic             div_done;
  logic             rsp_valid, rsp_ready;
  logic [15:0]      rsp_quotient;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dbz, rsp_timeout, busy;

  logic        model_done = 1'b0, stray_done = 1'b0;
  logic [15:0] model_q = '0, stray_q = '0;
  assign div_done     = model_done | stray_done;
  assign div_quotient = stray_done ? stray_q : model_q;

  always #5 clk = ~clk;

  alu_div_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_done(div_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_tag(rsp_tag),
    .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct {
    logic [15:0]      q;
    logic [TAG_W-1:0] tag;
    bit               dbz;
    bit               to;
  } exp_t;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    int               lat;
    logic [15:0]      q;
    bit               dbz;
  } vec_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   errs = 0, checks = 0;
  int   starts = 0, stab_err = 0, hold_err = 0, pushed = 0;
  bit   never_done = 1'b0, rand_rr = 1'b0;

  // Signed division truncating toward zero; zero divisor answers 0.
  function automatic int div_ref(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return (ib == 0) ? 0 : ia / ib;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag,
                      input int lat, input logic [15:0] q, input bit dbz, input bit to);
    int   n;
    bit   hs;
    exp_t e;
    req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
    n = 0; hs = 1'b0;
    while (!hs && n < 500) begin
      @(negedge clk); hs = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    chk("push_accept", hs, 1);
    if (hs) begin
      e.q = q; e.tag = tag; e.dbz = dbz; e.to = to;
      exp_q.push_back(e);
      if (!dbz) lat_q.push_back(lat);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 400) begin
      @(negedge clk); n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    step();
  endtask

  // Divider model: latency per request from lat_q, quotient from presented operands.
  logic [7:0] cap_a, cap_b;
  int         cnt_m;
  bit         busy_m = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      busy_m = 1'b0; model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (div_start) begin
        starts++;
        cap_a = div_a; cap_b = div_b;
        busy_m = !never_done;
        cnt_m = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      end else if (busy_m) begin
        if (div_a !== cap_a || div_b !== cap_b) stab_err++;
        if (cnt_m <= 1) begin
          model_done = 1'b1;
          model_q = 16'(div_ref(cap_a, cap_b));
          busy_m = 1'b0;
        end else cnt_m--;
      end
    end
  end

  // In-order response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL rsp_unexpected: got tag=%0d q=%0d with nothing outstanding", rsp_tag, $signed(rsp_quotient));
      end else begin
        e = exp_q.pop_front();
        if (rsp_quotient !== e.q || rsp_tag !== e.tag || rsp_dbz !== e.dbz || rsp_timeout !== e.to) begin
          errs++;
          $display("FAIL rsp_match: got q=%0d tag=%0d dbz=%0d to=%0d expected q=%0d tag=%0d dbz=%0d to=%0d",
                   $signed(rsp_quotient), rsp_tag, rsp_dbz, rsp_timeout,
                   $signed(e.q), e.tag, e.dbz, e.to);
        end
      end
    end
  end

  // A pending response must stay valid and unchanged until accepted.
  logic             pv = 1'b0, pr = 1'b0, pd, pto;
  logic [15:0]      pq;
  logic [TAG_W-1:0] pt;
  always @(negedge clk) begin
    if (reset && pv && !pr &&
        (rsp_valid !== 1'b1 || rsp_quotient !== pq || rsp_tag !== pt || rsp_dbz !== pd || rsp_timeout !== pto))
      hold_err++;
    pv = rsp_valid; pr = rsp_ready; pq = rsp_quotient; pt = rsp_tag; pd = rsp_dbz; pto = rsp_timeout;
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  vec_t       vec[10];
  int         s0, n, nrv, gap;
  logic [7:0] ra, rb;

  initial begin
    req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1; reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_ab", {div_a, div_b}, 0);
    chk("rst_rsp_fields", {rsp_quotient, rsp_tag, rsp_dbz, rsp_timeout}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step();

    vec[0] = '{8'd100,   8'd7,    4'd3,  11, 16'd14,     1'b0};
    vec[1] = '{-8'sd100, 8'd7,    4'd4,  6,  -16'sd14,   1'b0};
    vec[2] = '{-8'sd128, -8'sd1,  4'd5,  4,  16'sh0080,  1'b0};
    vec[3] = '{8'd55,    8'd0,    4'd9,  0,  16'd0,      1'b1};
    vec[4] = '{8'd127,   -8'sd128,4'd6,  1,  16'd0,      1'b0};
    vec[5] = '{-8'sd128, 8'd2,    4'd7,  2,  -16'sd64,   1'b0};
    vec[6] = '{8'd7,     -8'sd7,  4'd8,  3,  -16'sd1,    1'b0};
    vec[7] = '{-8'sd7,   8'd2,    4'd10, 1,  -16'sd3,    1'b0};
    vec[8] = '{8'd0,     8'd5,    4'd11, 5,  16'd0,      1'b0};
    vec[9] = '{-8'sd1,   8'd0,    4'd12, 0,  16'd0,      1'b1};

    for (int i = 0; i < 10; i++) begin
      s0 = starts;
      push(vec[i].a, vec[i].b, vec[i].tag, vec[i].lat, vec[i].q, vec[i].dbz, 1'b0);
      if (vec[i].dbz) begin
        @(negedge clk); chk("dbz_idle_cycle", rsp_valid, 0);
        @(negedge clk); chk("dbz_resp_cycle", rsp_valid, 1);
      end
      drain("vec");
      chk("vec_start_count", starts - s0, vec[i].dbz ? 0 : 1);
    end

    // Backpressure: first request issued, two queued, fourth held off.
    rsp_ready = 1'b0; s0 = starts; pushed = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          push(8'(20 * (i + 1)), 8'd3, 4'(i + 1), 3, 16'(div_ref(8'(20 * (i + 1)), 8'd3)), 1'b0, 1'b0);
          pushed++;
        end
      end
      begin
        repeat (30) @(negedge clk);
        chk("bp_pushed", pushed, 3);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_one_start", starts - s0, 1);
        step();
        rsp_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_starts", starts - s0, 4);

    // Watchdog: divider never answers, then stray done pulses.
    never_done = 1'b1; rsp_ready = 1'b0; s0 = starts;
    push(8'd50, 8'd5, 4'd13, 1, 16'd0, 1'b0, 1'b1);
    n = 0;
    while (!div_start && n < 20) begin @(negedge clk); n++; end
    chk("wd_start_seen", div_start, 1);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("wd_latency", n, TIMEOUT + 1);
    chk("wd_timeout_flag", rsp_timeout, 1);
    chk("wd_quotient", rsp_quotient, 0);
    step();
    stray_q = 16'h1234; stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    @(negedge clk);
    chk("wd_stray_q", rsp_quotient, 0);
    chk("wd_stray_to", rsp_timeout, 1);
    step();
    rsp_ready = 1'b1;
    drain("wd");
    never_done = 1'b0;
    stray_q = 16'h0055; stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    nrv = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) nrv++; end
    chk("wd_idle_stray_rsp", nrv, 0);
    chk("wd_idle_busy", busy, 0);
    chk("wd_starts", starts - s0, 1);
    step();

    // Random traffic with random consumer backpressure.
    rand_rr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      push(ra, rb, 4'(i), $urandom_range(1, 20), 16'(div_ref(ra, rb)), rb == 8'd0, 1'b0);
    end
    rand_rr = 1'b0;
    step();
    rsp_ready = 1'b1;
    drain("rand");

    // Reset during WAIT with one request still queued.
    s0 = starts;
    push(8'd20, 8'd3, 4'd1, 25, 16'd6, 1'b0, 1'b0);
    push(8'd21, 8'd3, 4'd2, 25, 16'd7, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_started", starts - s0, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_async_ready", req_ready, 1);
    chk("rst_async_outs", {div_start, div_a, div_b, rsp_valid, rsp_quotient, rsp_tag, rsp_dbz, rsp_timeout, busy}, 0);
    exp_q.delete(); lat_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    nrv = 0;
    repeat (40) begin @(negedge clk); if (rsp_valid) nrv++; end
    chk("rst_no_rsp", nrv, 0);
    chk("rst_no_restart", starts - s0, 1);
    chk("rst_post_busy", busy, 0);

    chk("div_ab_stable", stab_err, 0);
    chk("rsp_hold", hold_err, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_div_ctrl.md
Name: alu_div_ctrl

Overview:
Request front-end that sits directly upstream of the ALU's non-restoring divider. It buffers signed 8-bit division requests in a small FIFO and issues them one at a time to the divider. Issuing means holding the operands stable and pulsing start, then waiting for the divider's done pulse. The block captures the 16-bit quotient and returns it with a tag over a valid/ready response port. Divide-by-zero requests are short-circuited, and a watchdog catches a divider that never answers.

Parameters:
FIFO_DEPTH, 2, request FIFO entries (power of two, >=2)
TAG_W, 4, width of request/response tag
TIMEOUT, 32, max WAIT cycles before the watchdog fires (>=12)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request offered
req_ready  out  1  request FIFO can accept
req_a  in  8  signed dividend
req_b  in  8  signed divisor
req_tag  in  TAG_W  request tag, returned unchanged
div_start  out  1  start pulse to divider
div_a  out  8  dividend to divider, held stable
div_b  out  8  divisor to divider, held stable
div_quotient  in  16  signed quotient from divider
div_done  in  1  one-cycle completion pulse from divider
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_quotient  out  16  signed quotient
rsp_tag  out  TAG_W  tag of the answered request
rsp_dbz  out  1  divisor was zero
rsp_timeout  out  1  watchdog fired
busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (reset=0, async), all to 0: FIFO empties (req_ready=1), FSM to IDLE, div_start, div_a, div_b, rsp_*, busy, watchdog counter. Reset mid-WAIT abandons the request with no response.
- FIFO push: when req_valid && req_ready, store {a,b,tag}. req_ready = !full; there is no bypass. Pop happens only from IDLE. Push and pop in the same cycle are legal; the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, FIFO non-empty: pop the head entry into div_a, div_b and the tag register.
  - If b==0: go to RESP with rsp_quotient=0, rsp_dbz=1. The divider is never started.
  - Otherwise: go to ISSUE.
- ISSUE: div_start=1 for exactly this one cycle. Clear the watchdog. Next state is WAIT.
- WAIT: div_start=0 and the watchdog increments each cycle.
  - On div_done=1: capture div_quotient into rsp_quotient (dbz=0, timeout=0) and go to RESP.
  - Else, when the counter reaches TIMEOUT-1: set rsp_quotient=0, rsp_timeout=1 and go to RESP.
  - If div_done and the timeout coincide, div_done wins.
- RESP: rsp_valid=1, with rsp_quotient, rsp_tag, rsp_dbz and rsp_timeout held stable. When rsp_ready=1, the response transfers; rsp_valid goes low next cycle and the FSM returns to IDLE. rsp_valid never drops without rsp_ready.
- div_a and div_b change only on a pop from IDLE. They stay constant from ISSUE through the end of WAIT, because the divider re-reads the divisor in its final state.
- div_done is ignored in every state except WAIT; a late pulse after a timeout is dropped.
- Minimum per request: 1 cycle IDLE, 1 cycle ISSUE, divider latency, 1 cycle RESP. The next pop happens in the IDLE cycle that follows the handshake.
- Responses come out in request order. At most one request is in flight.

Test Plan:
- Push a=100, b=7, tag=3 with a divider model returning 14 after 11 cycles. Required: exactly one div_start pulse, div_a/div_b stable until div_done, then rsp_valid with quotient=14, tag=3, dbz=0, timeout=0.
- Sign handling: push a=-100, b=7, then a=-128, b=-1. Required: responses -14 then +128 (16'sh0080), in order.
- Divide by zero: push a=55, b=0, tag=9. Required: div_start never asserts; RESP two cycles after the push with quotient=0, dbz=1, tag=9.
- Backpressure: hold rsp_ready=0 and push 4 requests back-to-back. Required: the first is issued; req_ready drops after the FIFO holds 2 more; on release, tags come out in order with no loss or duplication.
- Watchdog: the divider model never asserts done. Required: rsp_timeout=1 and quotient=0 after TIMEOUT WAIT cycles; a later stray div_done pulse has no effect.
- Reset: assert reset during WAIT with 1 entry queued. Required: all outputs 0 asynchronously, req_ready=1, and no response after release.
